sub6_serial: RTL and testbench

- Multi-cycle, bit-serial inverse of adder6. Takes a 7-bit sum and a 6-bit addend b, and recovers a = sum - b.
- Processes one bit per clock, LSB first, using a single full-subtractor cell.
- Uses a start/busy/done handshake.
- Sits beside adder6 in the arithmetic block set and is used for round-trip checking of adder results (adder6 -> sub6_serial -> original a).

---
 rtl/arith_pkg.sv | 25 ++
 rtl/fsub1.sv | 21 ++
 rtl/sub6_serial.sv | 127 ++++++++++++
 tb/tb_sub6_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// Module : arith_pkg
// Shared types and constants for the serial arithmetic block set.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package arith_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fsub1.sv
// ----------------------------------------------------------------------------
// Module : fsub1
// Combinational 1-bit full subtractor: d = s - b - bin, with borrow out.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fsub1 (
    input  logic s,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = s ^ b ^ bin;
    assign bout = (~s & b) | (~(s ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/sub6_serial.sv
// ----------------------------------------------------------------------------
// Module : sub6_serial
// Bit-serial subtractor recovering a = sum - b, LSB first, with a
// start/busy/done handshake.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sub6_serial
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a,
    output logic             borrow,
    output logic             range_err
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             borrow_q, borrow_d;
    logic             rerr_q, rerr_d;

    logic w_d;
    logic w_bout;

    fsub1 u_fsub1 (
        .s    (sum_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (w_d),
        .bout (w_bout)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        borrow_d = borrow_q;
        rerr_d   = rerr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = sum;
                    b_d     = {1'b0, b};
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Operands drain from bit 0; the difference fills in from the MSB end.
                sum_d = sum_q >> 1;
                b_d   = b_q >> 1;
                res_d = {w_d, res_q[WIDTH:1]};
                br_d  = w_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    a_d      = res_d[WIDTH-1:0];
                    borrow_d = w_bout;
                    rerr_d   = w_bout | res_d[WIDTH];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sum_q    <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            borrow_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            borrow_q <= borrow_d;
            rerr_q   <= rerr_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign a         = a_q;
    assign borrow    = borrow_q;
    assign range_err = rerr_q;

endmodule

`default_nettype wire

// File: tb/tb_sub6_serial.sv
// ----------------------------------------------------------------------------
// Module : tb_sub6_serial
// Self-checking bench for sub6_serial: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sub6_serial;

    localparam int WIDTH = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a;
    logic             borrow;
    logic             range_err;

    int errors = 0;
    int checks = 0;

    sub6_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sum       (sum),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .a         (a),
        .borrow    (borrow),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int bv;
        int ea;
        int eb;
        int er;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, optionally poking start mid-run, and check the
    // handshake timing and results.
    task automatic run_op(input int s, input int bv, input int ea, input int eb,
                          input int er, input string nm, input bit glitch);
        int busy_n;
        int lat;
        int extra;
        sum   = 7'(s);
        b     = 6'(bv);
        start = 1'b1;
        tick();
        start  = 1'b0;
        sum    = 7'($urandom);
        b      = 6'($urandom);
        busy_n = busy ? 1 : 0;
        lat    = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = glitch && (c == 2);
            if (start) begin
                sum = 7'd100;
                b   = 6'd1;
            end
            if (busy) busy_n++;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        chk({nm, " latency"}, lat, 7);
        chk({nm, " a"}, int'(a), ea);
        chk({nm, " borrow"}, int'(borrow), eb);
        chk({nm, " range_err"}, int'(range_err), er);
        chk({nm, " busy_cycles"}, busy_n, 8);
        tick();
        chk({nm, " done_pulse"}, int'(done), 0);
        chk({nm, " busy_release"}, int'(busy), 0);
        if (glitch) begin
            extra = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (done) extra++;
            end
            chk({nm, " extra_done"}, extra, 0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int s, bv, diff, n_done, d0, d1;
        start = 1'b0;
        sum   = '0;
        b     = '0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset a", int'(a), 0);
        chk("reset borrow", int'(borrow), 0);
        chk("reset range_err", int'(range_err), 0);
        tick();

        vecs.push_back('{33, 28, 5, 0, 0});
        vecs.push_back('{45, 15, 30, 0, 0});
        vecs.push_back('{127, 63, 0, 0, 1});
        vecs.push_back('{10, 20, 54, 1, 1});
        vecs.push_back('{0, 63, 1, 1, 1});
        vecs.push_back('{127, 0, 63, 0, 1});
        vecs.push_back('{63, 63, 0, 0, 0});
        vecs.push_back('{64, 1, 63, 0, 0});
        foreach (vecs[i])
            run_op(vecs[i].s, vecs[i].bv, vecs[i].ea, vecs[i].eb, vecs[i].er,
                   $sformatf("vec%0d", i), 1'b0);

        // Mid-run start with new operands must be ignored.
        run_op(0, 0, 0, 0, 0, "ignore_start", 1'b1);

        // Leave nonzero results behind so the reset clearing is visible.
        run_op(10, 20, 54, 1, 1, "pre_abort", 1'b0);
        sum   = 7'd33;
        b     = 6'd28;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort a", int'(a), 0);
        chk("abort borrow", int'(borrow), 0);
        chk("abort range_err", int'(range_err), 0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) n_done++;
        end
        chk("abort no_done", n_done, 0);
        run_op(33, 28, 5, 0, 0, "post_abort", 1'b0);

        // Start held high re-triggers every WIDTH+3 cycles.
        sum   = 7'd45;
        b     = 6'd15;
        start = 1'b1;
        d0    = -1;
        d1    = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) begin
                if (d0 < 0) d0 = c;
                else if (d1 < 0) d1 = c;
            end
        end
        start = 1'b0;
        chk("held spacing", d1 - d0, WIDTH + 3);
        chk("held a", int'(a), 30);
        for (int c = 0; c < 20 && busy; c++) tick();
        chk("held idle", int'(busy), 0);

        // Randomized operations against modular arithmetic.
        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(0, 127));
            bv   = int'($urandom_range(0, 63));
            diff = (s - bv + 128) % 128;
            run_op(s, bv, diff % 64, (s < bv) ? 1 : 0,
                   ((s < bv) || (diff >= 64)) ? 1 : 0,
                   $sformatf("rand%0d", i), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
